// File: rtl/axi_pkg.sv
// Shared AXI widths, response codes and channel FSM state types.
package axi_pkg;

    localparam int unsigned AXI_IDS_BITS  = 8;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_LEN_BITS  = 4;
    localparam int unsigned AXI_SIZE_BITS = 3;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_STRB_BITS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        RIdle,
        RData
    } rd_state_t;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } wr_state_t;

endpackage

// File: rtl/default_slave.sv
// AXI default slave: terminates unmapped accesses with DECERR, honouring full burst lengths.
module default_slave
    import axi_pkg::*;
(
    input  logic                     ACLK,
    input  logic                     ARESETn,

    input  logic [AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,

    output logic [AXI_IDS_BITS-1:0]  RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,

    input  logic [AXI_IDS_BITS-1:0]  AWID_S,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
    input  logic [1:0]               AWBURST_S,
    input  logic                     AWVALID_S,
    output logic                     AWREADY_S,

    input  logic [AXI_DATA_BITS-1:0] WDATA_S,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_S,
    input  logic                     WLAST_S,
    input  logic                     WVALID_S,
    output logic                     WREADY_S,

    output logic [AXI_IDS_BITS-1:0]  BID_S,
    output logic [1:0]               BRESP_S,
    output logic                     BVALID_S,
    input  logic                     BREADY_S
);

    rd_state_t               r_state_q, r_state_d;
    logic [AXI_IDS_BITS-1:0] rid_q, rid_d;
    logic [AXI_LEN_BITS-1:0] rcnt_q, rcnt_d;
    logic                    ar_ready_q, ar_ready_d;

    wr_state_t               w_state_q, w_state_d;
    logic [AXI_IDS_BITS-1:0] bid_q, bid_d;
    logic                    aw_ready_q, aw_ready_d;

    // Address, size, burst type and write payload carry no meaning for a sink.
    logic unused_inputs;
    assign unused_inputs = ^{ARADDR_S, ARSIZE_S, ARBURST_S, AWADDR_S, AWLEN_S,
                             AWSIZE_S, AWBURST_S, WDATA_S, WSTRB_S};

    // Read FSM next state: latch ID/length on AR, count beats down to the last.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rcnt_d    = rcnt_q;
        unique case (r_state_q)
            RIdle: begin
                if (ARVALID_S && ar_ready_q) begin
                    rid_d     = ARID_S;
                    rcnt_d    = ARLEN_S;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (RREADY_S) begin
                    if (rcnt_q == '0) begin
                        r_state_d = RIdle;
                    end else begin
                        rcnt_d = rcnt_q - AXI_LEN_BITS'(1);
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
        // Registered ready so it stays low through reset and rises one edge after release.
        ar_ready_d = (r_state_d == RIdle);
    end

    // Read FSM state and context registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q  <= RIdle;
            rid_q      <= '0;
            rcnt_q     <= '0;
            ar_ready_q <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            rid_q      <= rid_d;
            rcnt_q     <= rcnt_d;
            ar_ready_q <= ar_ready_d;
        end
    end

    // Write FSM next state: take AW, drain W until WLAST, then hold B until accepted.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        unique case (w_state_q)
            WIdle: begin
                if (AWVALID_S && aw_ready_q) begin
                    bid_d     = AWID_S;
                    w_state_d = WData;
                end
            end
            WData: begin
                // AWLEN is deliberately not tracked; WLAST alone ends the burst.
                if (WVALID_S && WLAST_S) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                if (BREADY_S) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
        aw_ready_d = (w_state_d == WIdle);
    end

    // Write FSM state and context registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q  <= WIdle;
            bid_q      <= '0;
            aw_ready_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            bid_q      <= bid_d;
            aw_ready_q <= aw_ready_d;
        end
    end

    // Outputs decoded purely from registers; IDs and responses read as zero when idle.
    always_comb begin
        ARREADY_S = ar_ready_q;
        RVALID_S  = (r_state_q == RData);
        RDATA_S   = '0;
        RID_S     = RVALID_S ? rid_q : '0;
        RRESP_S   = RVALID_S ? RESP_DECERR : RESP_OKAY;
        RLAST_S   = RVALID_S && (rcnt_q == '0);

        AWREADY_S = aw_ready_q;
        WREADY_S  = (w_state_q == WData);
        BVALID_S  = (w_state_q == WResp);
        BID_S     = BVALID_S ? bid_q : '0;
        BRESP_S   = BVALID_S ? RESP_DECERR : RESP_OKAY;
    end

endmodule
